rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: LL buffer entries (power of two, 2..8).
REQ-002 Parameter STARVE_LIMIT, default 4: wait cycles before the LL head is forced ahead of WB.
REQ-003 i_clk  in  1  single clock, all logic on rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_clk_enable  in  1  global advance enable.
REQ-006 i_wb_we / i_wb_addr / i_wb_data  in  1/5/32  pipeline writeback request, no backpressure except o_stall_req.
REQ-007 i_ll_valid / i_ll_addr / i_ll_data  in  1/5/32  long-latency unit write request.
REQ-008 o_ll_ready  out  1  LL handshake ready.
REQ-009 o_rf_we / o_rf_addr / o_rf_data  out  1/5/32  registered write port into the register file.
REQ-010 o_stall_req  out  1  pipeline shall hold WB while high.
REQ-011 o_pend_mask  out  32  bit n high = LL write to xn buffered, not yet retired.

Function
REQ-012 LL transfer occurs on an enabled cycle with i_ll_valid && o_ll_ready; entry pushed into an in-order FIFO.
REQ-013 o_ll_ready = enable && (count < DEPTH); no push while full, even with a same-cycle pop.
REQ-014 An LL transfer with i_ll_addr==0 is accepted and discarded (no push, no mask bit).
REQ-015 A WB request with i_wb_addr==0 is treated as no request.
REQ-016 FSM states: IDLE (FIFO empty), PEND (FIFO non-empty, WB priority), FORCE (LL head priority).
REQ-017 IDLE->PEND on push; PEND->IDLE when last entry pops with no push; PEND->FORCE when starve counter reaches STARVE_LIMIT; FORCE->PEND (or IDLE if empty) after the head pops.
REQ-018 Starve counter increments each enabled cycle in PEND where WB is granted, clears on any pop; saturates at STARVE_LIMIT.
REQ-019 Grant per enabled cycle: IDLE/PEND -> WB if requesting, else FIFO head; FORCE -> FIFO head, WB not granted.
REQ-020 o_stall_req = 1 combinationally while state==FORCE; otherwise 0.
REQ-021 Granted write appears on o_rf_* one cycle after the grant cycle; o_rf_we=0 on cycles with no grant.
REQ-022 WAW rule: when WB is granted to address A, every buffered entry with addr A is killed; killed entries pop without write and count as a pop.
REQ-023 A head entry killed and popped in the same cycle produces no o_rf_we.
REQ-024 o_pend_mask bit set on push, cleared on pop or kill of the last buffered entry for that address.
REQ-025 i_clk_enable=0: FSM, FIFO, counter, mask hold; o_rf_we=0 next cycle; o_ll_ready=0.

Reset
REQ-026 On rising edge with i_rst_n=0: FIFO empty, count 0, starve counter 0, state IDLE, o_rf_we/addr/data 0, o_pend_mask 0.
REQ-027 Reset mid-operation discards all buffered LL entries with no write; o_ll_ready/o_stall_req 0 during reset.

Configuration
REQ-028 Macro RF_ARB_SCOREBOARD_EN: defined -> o_pend_mask and kill logic (REQ-022..024) present; undefined -> o_pend_mask tied 0, no kill, entries retire in order regardless of WB address.

Structure
REQ-029 Shared package rf_arb_pkg: FSM state enum (IDLE/PEND/FORCE), 5-bit register address and 32-bit data widths, FIFO entry struct {addr, data, kill}.
REQ-030 One sub-module rf_arb_fifo (DEPTH-entry in-order buffer with per-entry kill compare); FSM and grant logic in the top.

Verification
REQ-031 Reset, then LL push x5=0xDEAD_BEEF with no WB -> o_rf_we=1, addr 5, data 0xDEADBEEF exactly 2 cycles after handshake; mask bit 5 high then low.
REQ-032 WB x3=0x11 every cycle while LL x7=0x22 buffered, STARVE_LIMIT=4 -> o_stall_req high on 5th cycle, x7 written next cycle, stall drops.
REQ-033 Fill FIFO (DEPTH=2) with x1, x2 under continuous WB -> o_ll_ready=0, third valid held; accepted after first pop.
REQ-034 LL x9=0xAA buffered, then WB x9=0xBB granted -> only 0xBB written to x9; mask bit 9 clears; (macro off: 0xAA written after 0xBB).
REQ-035 LL x0 transfer and WB x0 -> no o_rf_we, mask unchanged; i_clk_enable=0 for 3 cycles mid-PEND -> state, count frozen, o_rf_we=0.
REQ-036 Assert i_rst_n=0 with 2 entries buffered and FSM in FORCE -> next cycle all outputs 0, state IDLE, no write of buffered data after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write arbiter
// (the kill/pending-mask scoreboard is built in when RF_ARB_SCOREBOARD_EN is defined).
package rf_arb_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              kill;
    } fifo_entry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        addr_onehot = NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order buffer of long-latency register writes with per-entry kill compare.
// Kill and pending-mask logic are active only when KILL_EN is set by the parent.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter bit          KILL_EN = 1'b0,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_push,
    input  logic [ADDR_W-1:0]   i_push_addr,
    input  logic [DATA_W-1:0]   i_push_data,
    input  logic                i_pop,
    input  logic                i_kill_en,
    input  logic [ADDR_W-1:0]   i_kill_addr,
    output logic [ADDR_W-1:0]   o_head_addr,
    output logic [DATA_W-1:0]   o_head_data,
    output logic                o_head_kill,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_empty,
    output logic                o_full,
    output logic [NUM_REGS-1:0] o_pend_mask
);

    fifo_entry_t          entries_q [DEPTH];
    fifo_entry_t          entries_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_REGS-1:0]  pend_mask;

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q + CNT_W'(i_push) - CNT_W'(i_pop);

        // A newer writeback to the same register makes every buffered copy stale.
        if (KILL_EN && i_kill_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[PTR_W'(i)] && (entries_q[PTR_W'(i)].addr == i_kill_addr)) begin
                    entries_d[PTR_W'(i)].kill = 1'b1;
                end
            end
        end

        if (i_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        // Push only happens when not full, so it never lands on the slot being popped.
        if (i_push) begin
            entries_d[wr_ptr_q] = '{addr: i_push_addr, data: i_push_data, kill: 1'b0};
            valid_d[wr_ptr_q]   = 1'b1;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        pend_mask = '0;
        if (KILL_EN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[PTR_W'(i)] && !entries_q[PTR_W'(i)].kill) begin
                    pend_mask = pend_mask | addr_onehot(entries_q[PTR_W'(i)].addr);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PTR_W'(i)] <= '0;
            end
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign o_head_addr = entries_q[rd_ptr_q].addr;
    assign o_head_data = entries_q[rd_ptr_q].data;
    assign o_head_kill = entries_q[rd_ptr_q].kill;
    assign o_count     = count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == CNT_W'(DEPTH));
    assign o_pend_mask = pend_mask;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a
// buffered long-latency unit. Define RF_ARB_SCOREBOARD_EN for WAW kill and o_pend_mask.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_enable,
    input  logic                i_wb_we,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    input  logic [DATA_W-1:0]   i_wb_data,
    input  logic                i_ll_valid,
    input  logic [ADDR_W-1:0]   i_ll_addr,
    input  logic [DATA_W-1:0]   i_ll_data,
    output logic                o_ll_ready,
    output logic                o_rf_we,
    output logic [ADDR_W-1:0]   o_rf_addr,
    output logic [DATA_W-1:0]   o_rf_data,
    output logic                o_stall_req,
    output logic [NUM_REGS-1:0] o_pend_mask
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

`ifdef RF_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    arb_state_e          state_q, state_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;

    logic                wb_req;
    logic                ll_ready;
    logic                wb_grant;
    logic                head_grant;
    logic                head_kill_now;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count_nxt;

    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                head_kill;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic [NUM_REGS-1:0] fifo_mask;

    assign wb_req   = i_wb_we && (i_wb_addr != '0);
    assign ll_ready = i_rst_n && i_clk_enable && !fifo_full;

    rf_arb_fifo #(
        .DEPTH   (DEPTH),
        .KILL_EN (SB_EN)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_addr (i_ll_addr),
        .i_push_data (i_ll_data),
        .i_pop       (pop),
        .i_kill_en   (wb_grant),
        .i_kill_addr (i_wb_addr),
        .o_head_addr (head_addr),
        .o_head_data (head_data),
        .o_head_kill (head_kill),
        .o_count     (fifo_count),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full),
        .o_pend_mask (fifo_mask)
    );

    // Grant, FIFO control, starvation tracking and next state.
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        rf_we_d       = 1'b0;
        rf_addr_d     = rf_addr_q;
        rf_data_d     = rf_data_q;
        wb_grant      = 1'b0;
        head_grant    = 1'b0;
        head_kill_now = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        count_nxt     = fifo_count;

        if (i_clk_enable) begin
            push = i_ll_valid && ll_ready && (i_ll_addr != '0);

            if (state_q == ST_FORCE) begin
                head_grant = !fifo_empty;
            end else if (wb_req) begin
                wb_grant = 1'b1;
            end else begin
                head_grant = !fifo_empty;
            end

            // A head entry overwritten by this writeback leaves without a write.
            head_kill_now = SB_EN && wb_grant && !fifo_empty && (head_addr == i_wb_addr);
            pop           = !fifo_empty && (head_grant || head_kill || head_kill_now);
            count_nxt     = fifo_count + CNT_W'(push) - CNT_W'(pop);

            if (wb_grant) begin
                rf_we_d   = 1'b1;
                rf_addr_d = i_wb_addr;
                rf_data_d = i_wb_data;
            end else if (head_grant && !head_kill) begin
                rf_we_d   = 1'b1;
                rf_addr_d = head_addr;
                rf_data_d = head_data;
            end

            if (pop) begin
                starve_d = '0;
            end else if ((state_q == ST_PEND) && wb_grant && (starve_q < STV_W'(STARVE_LIMIT))) begin
                starve_d = starve_q + STV_W'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_d = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (count_nxt == '0) begin
                        state_d = ST_IDLE;
                    end else if (starve_d == STV_W'(STARVE_LIMIT)) begin
                        state_d = ST_FORCE;
                    end
                end
                ST_FORCE: begin
                    state_d = (count_nxt == '0) ? ST_IDLE : ST_PEND;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign o_ll_ready  = ll_ready;
    assign o_stall_req = i_rst_n && (state_q == ST_FORCE);
    assign o_rf_we     = rf_we_q;
    assign o_rf_addr   = rf_addr_q;
    assign o_rf_data   = rf_data_q;
    assign o_pend_mask = fifo_mask;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected register writes are queued with their
// expected cycle and checked by an independent write monitor.
module tb_rf_write_arbiter;

`ifdef RF_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ll_valid;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall;
    logic [31:0] pend_mask;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clk_enable (en),
        .i_wb_we      (wb_we),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .i_ll_valid   (ll_valid),
        .i_ll_addr    (ll_addr),
        .i_ll_data    (ll_data),
        .o_ll_ready   (ll_ready),
        .o_rf_we      (rf_we),
        .o_rf_addr    (rf_addr),
        .o_rf_data    (rf_data),
        .o_stall_req  (stall),
        .o_pend_mask  (pend_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in the grant cycle; the registered write shows up one cycle later.
    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle_in();
        wb_we    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'h0;
        ll_valid = 1'b0;
        ll_addr  = 5'd0;
        ll_data  = 32'h0;
    endtask

    function automatic logic [31:0] m(input logic [31:0] v);
        return SB ? v : 32'h0;
    endfunction

    // Write monitor: every register-file write must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual addr=%0d data=0x%08h required no write (cycle %0d)",
                             rf_addr, rf_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(rf_addr), 32'(e.a));
                    chk("wr_data", rf_data, e.d);
                    chk("wr_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        idle_in();

        // Reset state
        tick(); tick(); #1;
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_mask", pend_mask, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_ll_ready", 32'(ll_ready), 32'h0);
        rst_n = 1'b1; #1;
        chk("ready_after_rst", 32'(ll_ready), 32'h1);
        tick();

        // Single LL write with no writeback traffic
        ll_valid = 1'b1; ll_addr = 5'd5; ll_data = 32'hDEAD_BEEF; #1;
        chk("t1_ready", 32'(ll_ready), 32'h1);
        tick(); ll_valid = 1'b0; #1;
        chk("t1_mask_set", pend_mask, m(32'h0000_0020));
        exp_wr(5'd5, 32'hDEAD_BEEF);
        tick(); #1;
        chk("t1_mask_clr", pend_mask, 32'h0);
        chk("t1_stall", 32'(stall), 32'h0);
        tick();
        chk("t1_drain", 32'(exp_q.size()), 32'h0);

        // Starvation forces the LL head ahead of continuous writeback
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'h22; #1;
        exp_wr(5'd3, 32'h11);
        for (int k = 1; k <= 4; k++) begin
            tick(); ll_valid = 1'b0; #1;
            chk("t2_no_stall", 32'(stall), 32'h0);
            exp_wr(5'd3, 32'h11);
        end
        tick(); #1;
        chk("t2_stall", 32'(stall), 32'h1);
        exp_wr(5'd7, 32'h22);
        tick(); #1;
        chk("t2_stall_drop", 32'(stall), 32'h0);
        exp_wr(5'd3, 32'h11);
        tick(); idle_in();
        tick();
        chk("t2_drain", 32'(exp_q.size()), 32'h0);

        // Full FIFO holds off the third LL request until the first pop
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        ll_valid = 1'b1; ll_addr = 5'd1; ll_data = 32'hA1; #1;
        chk("t3_ready_empty", 32'(ll_ready), 32'h1);
        exp_wr(5'd3, 32'h33);
        tick(); ll_addr = 5'd2; ll_data = 32'hA2; #1;
        chk("t3_ready_one", 32'(ll_ready), 32'h1);
        exp_wr(5'd3, 32'h33);
        tick(); ll_addr = 5'd4; ll_data = 32'hA4; #1;
        chk("t3_full", 32'(ll_ready), 32'h0);
        chk("t3_mask", pend_mask, m(32'h0000_0006));
        exp_wr(5'd3, 32'h33);
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            chk("t3_full_held", 32'(ll_ready), 32'h0);
            exp_wr(5'd3, 32'h33);
        end
        tick(); #1;
        chk("t3_full_on_pop", 32'(ll_ready), 32'h0);
        chk("t3_force", 32'(stall), 32'h1);
        exp_wr(5'd1, 32'hA1);
        tick(); #1;
        chk("t3_ready_after_pop", 32'(ll_ready), 32'h1);
        exp_wr(5'd3, 32'h33);
        tick(); idle_in(); #1;
        exp_wr(5'd2, 32'hA2);
        tick(); #1;
        exp_wr(5'd4, 32'hA4);
        tick(); tick();
        chk("t3_drain", 32'(exp_q.size()), 32'h0);

        // WAW: writeback to a buffered non-head register
        ll_valid = 1'b1; ll_addr = 5'd8; ll_data = 32'h88;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h31; #1;
        exp_wr(5'd3, 32'h31);
        tick(); ll_addr = 5'd9; ll_data = 32'hAA; wb_data = 32'h32; #1;
        exp_wr(5'd3, 32'h32);
        tick(); ll_valid = 1'b0; wb_addr = 5'd9; wb_data = 32'hBB; #1;
        chk("t4_mask_both", pend_mask, m(32'h0000_0300));
        exp_wr(5'd9, 32'hBB);
        tick(); wb_we = 1'b0; #1;
        chk("t4_mask_killed", pend_mask, m(32'h0000_0100));
        exp_wr(5'd8, 32'h88);
        tick(); #1;
        chk("t4_mask_clear", pend_mask, 32'h0);
        if (!SB) exp_wr(5'd9, 32'hAA);
        tick(); tick();
        chk("t4_drain", 32'(exp_q.size()), 32'h0);

        // WAW: writeback kills the head entry in the cycle it would pop
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'hCC; #1;
        tick(); ll_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hDD; #1;
        chk("t4_head_mask", pend_mask, m(32'h0000_0200));
        exp_wr(5'd9, 32'hDD);
        tick(); wb_we = 1'b0; #1;
        chk("t4_head_mask_clr", pend_mask, 32'h0);
        chk("t4_head_ready", 32'(ll_ready), 32'h1);
        if (!SB) exp_wr(5'd9, 32'hCC);
        tick(); tick();
        chk("t4_head_drain", 32'(exp_q.size()), 32'h0);

        // Register x0 requests from either side are dropped
        ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'h55;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h66; #1;
        chk("t5_x0_ready", 32'(ll_ready), 32'h1);
        tick(); idle_in(); #1;
        chk("t5_x0_mask", pend_mask, 32'h0);
        chk("t5_x0_we1", 32'(rf_we), 32'h0);
        chk("t5_x0_stall", 32'(stall), 32'h0);
        tick(); #1;
        chk("t5_x0_we2", 32'(rf_we), 32'h0);

        // Clock enable low for three cycles in PEND freezes everything
        ll_valid = 1'b1; ll_addr = 5'd12; ll_data = 32'hC0;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h35; #1;
        exp_wr(5'd3, 32'h35);
        tick(); ll_valid = 1'b0; en = 1'b0; #1;
        chk("t5_ready_dis", 32'(ll_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            chk("t5_we_dis", 32'(rf_we), 32'h0);
            chk("t5_mask_dis", pend_mask, m(32'h0000_1000));
            chk("t5_ready_dis", 32'(ll_ready), 32'h0);
        end
        tick(); en = 1'b1; wb_we = 1'b0; #1;
        chk("t5_we_last_dis", 32'(rf_we), 32'h0);
        chk("t5_mask_resume", pend_mask, m(32'h0000_1000));
        exp_wr(5'd12, 32'hC0);
        tick(); tick();
        chk("t5_drain", 32'(exp_q.size()), 32'h0);

        // Reset while in FORCE with two entries buffered
        ll_valid = 1'b1; ll_addr = 5'd13; ll_data = 32'hD1;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h41; #1;
        exp_wr(5'd3, 32'h41);
        tick(); ll_addr = 5'd14; ll_data = 32'hD2; #1;
        exp_wr(5'd3, 32'h41);
        for (int k = 0; k < 3; k++) begin
            tick(); ll_valid = 1'b0; #1;
            exp_wr(5'd3, 32'h41);
        end
        tick(); #1;
        chk("t6_force", 32'(stall), 32'h1);
        chk("t6_mask", pend_mask, m(32'h0000_6000));
        rst_n = 1'b0; wb_we = 1'b0; #1;
        chk("t6_stall_in_rst", 32'(stall), 32'h0);
        chk("t6_ready_in_rst", 32'(ll_ready), 32'h0);
        tick(); #1;
        chk("t6_rf_we", 32'(rf_we), 32'h0);
        chk("t6_rf_addr", 32'(rf_addr), 32'h0);
        chk("t6_rf_data", rf_data, 32'h0);
        chk("t6_mask_rst", pend_mask, 32'h0);
        chk("t6_stall_rst", 32'(stall), 32'h0);
        rst_n = 1'b1;
        tick(); tick(); tick(); #1;
        chk("t6_ready_after", 32'(ll_ready), 32'h1);
        chk("t6_stall_after", 32'(stall), 32'h0);
        chk("t6_mask_after", pend_mask, 32'h0);
        chk("t6_drain", 32'(exp_q.size()), 32'h0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
